shift_add_multiplier: RTL and testbench



---
 rtl/mult_pkg.sv | 15 +
 rtl/lookahead_carry_adder.sv | 42 ++++
 rtl/shift_add_multiplier.sv | 82 ++++++++
 tb/tb_shift_add_multiplier.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential multipliers.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width for a WIDTH-bit shift-and-add datapath.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/lookahead_carry_adder.sv
// WIDTH-bit adder with carry lookahead inside 4-bit groups; groups chain by group carry.
module lookahead_carry_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] g, p;
  logic [WIDTH:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded from its group's carry-in rather than the previous bit.
  always_comb begin
    int   base;
    logic t, pp;
    base = 0;
    t    = 1'b0;
    pp   = 1'b1;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      base = (i / 4) * 4;
      t    = 1'b0;
      pp   = 1'b1;
      for (int j = i; j >= base; j--) begin
        t  = t | (g[j] & pp);
        pp = pp & p[j];
      end
      c[i+1] = t | (pp & c[base]);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier: one partial-product add per cycle,
// WIDTH iterations, valid/ready on both sides.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] mcand, hi, lo, addend, sum;
  logic             cout;
  logic [CW-1:0]    cnt;
  logic             load, step;

  assign addend = lo[0] ? mcand : '0;

  lookahead_carry_adder #(.WIDTH(WIDTH)) u_add (
    .a    (hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        load     = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        mcand <= a;
        hi    <= '0;
        lo    <= b;
        cnt   <= '0;
      end else if (step) begin
        // Carry-out drops into hi's MSB so the 2W+1-bit partial sum is never truncated.
        {hi, lo} <= {cout, sum, lo[WIDTH-1:1]};
        cnt      <= cnt + CW'(1);
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = {hi, lo};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed WIDTH=16 checks plus a randomized WIDTH=8 stream against an a*b scoreboard.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int npass = 0;
  int ntot  = 0;
  int issued, got, dcyc, mcyc, seen;
  logic [15:0] q[$];

  shift_add_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .product(p16)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one operation, wait (bounded) for out_valid, check latency and product.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input string tag);
    int cyc;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(ir16), 64'd1);
    iv16 = 1'b1; a16 = a; b16 = b;
    @(negedge clk);
    iv16 = 1'b0;
    cyc  = 0;
    while (!ov16 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd16);
    chk({tag, "_product"}, 64'(p16), 64'(a) * 64'(b));
  endtask

  task automatic done16(input string tag);
    @(negedge clk);
    chk({tag, "_ov_drop"}, 64'(ov16), 64'd0);
    chk({tag, "_ir_back"}, 64'(ir16), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; or8  = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(ir16), 64'd1);
    chk("rst_out_valid", 64'(ov16), 64'd0);
    chk("rst_product", 64'(p16), 64'd0);
    rst = 1'b0;

    op16(16'd3, 16'd5, "m3x5");            done16("m3x5");
    op16(16'hFFFF, 16'hFFFF, "mmax");      done16("mmax");
    op16(16'h1234, 16'h0000, "mbzero");    done16("mbzero");
    op16(16'h0000, 16'hBEEF, "mazero");    done16("mazero");
    for (int i = 0; i < 4; i++) begin
      op16(16'($urandom), 16'($urandom), "mrand");
      done16("mrand");
    end

    // Backpressure: result must hold and stray in_valid must be ignored.
    or16 = 1'b0;
    op16(16'd7, 16'd9, "bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp_ov_hold", 64'(ov16), 64'd1);
      chk("bp_prod_hold", 64'(p16), 64'd63);
      chk("bp_ir_low", 64'(ir16), 64'd0);
      if (k == 1) begin iv16 = 1'b1; a16 = 16'd1; b16 = 16'd1; end
      if (k == 2) iv16 = 1'b0;
      @(negedge clk);
    end
    or16 = 1'b1;
    done16("bp");
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov16) seen++;
    end
    chk("bp_no_second", 64'(seen), 64'd0);

    // Reset lands on the 8th iteration edge.
    @(negedge clk);
    iv16 = 1'b1; a16 = 16'hABCD; b16 = 16'h1357;
    @(negedge clk);
    iv16 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 64'(ir16), 64'd1);
    chk("abort_out_valid", 64'(ov16), 64'd0);
    chk("abort_product", 64'(p16), 64'd0);
    op16(16'd100, 16'd200, "m100x200");    done16("m100x200");

    // WIDTH=8 random stream with random backpressure, in-order scoreboard.
    issued = 0; got = 0; dcyc = 0; mcyc = 0;
    fork
      begin
        while (issued < 1000 && dcyc < 30000) begin
          @(negedge clk);
          dcyc++;
          if (ir8 && !iv8 && $urandom_range(0, 3) != 0) begin
            iv8 = 1'b1;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            q.push_back(16'(a8) * 16'(b8));
            issued++;
          end else begin
            iv8 = 1'b0;
          end
        end
        @(negedge clk);
        iv8 = 1'b0;
      end
      begin
        while (got < 1000 && mcyc < 30000) begin
          @(negedge clk);
          mcyc++;
          or8 = ($urandom_range(0, 3) != 0);
          if (ov8 && or8) begin
            if (q.size() == 0) begin
              ntot++;
              $error("FAIL rnd_extra: observed product %0h expected no pending result", p8);
            end else begin
              chk("rnd_product", 64'(p8), 64'(q.pop_front()));
            end
            got++;
          end
        end
      end
    join
    chk("rnd_count", 64'(got), 64'd1000);
    chk("rnd_queue_empty", 64'(q.size()), 64'd0);
    or8 = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov8) seen++;
    end
    chk("rnd_no_extra", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
